inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, SHALL be the instruction word driven for bubbles.
REQ-003 Parameter EBREAK_INST, default 32'h0010_0073, SHALL be the encoding that halts fetch.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 i_clk  in  1  SHALL be the clock; all state updates on its rising edge.
REQ-006 i_rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 i_stall  in  1  SHALL request that the PC and IF/ID register hold.
REQ-008 i_flush  in  1  SHALL request that the IF/ID register be loaded with a bubble.
REQ-009 i_redirect  in  1  SHALL request that the PC be replaced with i_redirect_pc.
REQ-010 i_redirect_pc  in  32  SHALL be the branch/jump target.
REQ-011 o_addr_inst  out  32  SHALL be the fetch address presented to instruction memory.
REQ-012 i_inst  in  32  SHALL be the combinational instruction returned for o_addr_inst.
REQ-013 o_if_pc, o_if_pc4  out  32 each  SHALL be the PC and PC+4 of the IF/ID entry.
REQ-014 o_if_inst  out  32  SHALL be the IF/ID instruction word.
REQ-015 o_if_valid  out  1  SHALL be high when the IF/ID entry is a real instruction.
REQ-016 o_if_misalign  out  1  SHALL flag an entry fetched after a misaligned redirect.
REQ-017 o_halted  out  1  SHALL be high while the FSM is in HALT.
REQ-018 o_fetch_cnt  out  32  SHALL count instructions accepted into IF/ID.

Function
REQ-019 o_addr_inst SHALL equal the PC register combinationally, with zero added latency.
REQ-020 The FSM SHALL have states BOOT, RUN and HALT, and SHALL enter BOOT on reset.
REQ-021 BOOT SHALL last exactly one cycle, hold the PC, load a bubble, ignore all control inputs and then go to RUN.
REQ-022 In RUN, per-edge priority SHALL be: redirect > stall > normal fetch; i_flush applies independently to IF/ID.
REQ-023 Redirect: PC <= {i_redirect_pc[31:2],2'b00}; IF/ID <= bubble; misalign-pending <= (i_redirect_pc[1:0]!=0); fetch_cnt unchanged.
REQ-024 Stall without redirect: PC and fetch_cnt SHALL hold; IF/ID SHALL hold unless i_flush is high, in which case IF/ID <= bubble.
REQ-025 Normal fetch: IF/ID <= {PC, PC+4, i_inst, valid=1, misalign=pending}; pending <= 0; fetch_cnt += 1; PC <= PC+4.
REQ-026 If i_flush is high during a normal fetch, IF/ID SHALL load a bubble, the PC SHALL still advance, and fetch_cnt SHALL NOT increment.
REQ-027 A bubble SHALL be valid=0, inst=NOP_INST, misalign=0, with pc/pc4 unchanged.
REQ-028 PC+4 and fetch_cnt SHALL wrap modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-029 When a normal fetch accepts i_inst==EBREAK_INST, the EBREAK entry SHALL be latched, the PC SHALL hold, and the FSM SHALL go to HALT.
REQ-030 In HALT: PC holds; IF/ID SHALL load a bubble on every edge after the EBREAK entry unless stalled; o_halted=1; i_flush applies.
REQ-031 Redirect in HALT SHALL act per REQ-023 and return to RUN, squashing the speculative EBREAK.
REQ-032 Misalign-pending SHALL survive stalls and SHALL clear only when consumed by an accepted fetch or overwritten by a redirect.

Reset
REQ-033 Asserting i_rst_n low SHALL immediately force: PC=RESET_PC, o_if_valid=0, o_if_inst=NOP_INST, o_if_pc=0, o_if_pc4=0, o_if_misalign=0, pending=0, o_fetch_cnt=0, o_halted=0, state=BOOT.
REQ-034 Reset asserted mid-stall, mid-redirect or in HALT SHALL discard all in-flight state.

Verification
REQ-035 Release reset, i_inst=32'h0050_0093 constant -> edge 1: valid=0 (BOOT); edge 2: o_if_pc=0, valid=1; edge 3: o_if_pc=4, o_fetch_cnt=2.
REQ-036 PC=0x10, i_stall=1 for 3 cycles -> o_addr_inst stays 0x10 and IF/ID and fetch_cnt are unchanged; with stall and flush together -> valid=0 and PC=0x10.
REQ-037 i_redirect=1, i_redirect_pc=0x0000_0102, stall=1 -> PC=0x100, valid=0; next accepted fetch -> o_if_pc=0x100, o_if_misalign=1; the following fetch -> misalign=0.
REQ-038 Accepted i_inst=32'h0010_0073 at PC=0x40 -> o_if_inst=EBREAK, o_halted=1, o_addr_inst stays 0x40, then valid=0; redirect to 0x80 -> o_halted=0, PC=0x80.
REQ-039 Force PC=0xFFFF_FFFC via redirect and fetch -> o_if_pc4=0, next PC=0; fetch_cnt preset near 0xFFFF_FFFF wraps to 0.
REQ-040 Assert i_rst_n low asynchronously while in HALT with pending=1 -> all outputs take REQ-033 values before the next clock edge.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// fills the IF/ID register, with redirect/stall/flush control and EBREAK halting.
module inst_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_addr_inst,
  input  logic [31:0] i_inst,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc4,
  output logic [31:0] o_if_inst,
  output logic        o_if_valid,
  output logic        o_if_misalign,
  output logic        o_halted,
  output logic [31:0] o_fetch_cnt
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pending;

  logic take_redirect;
  logic accept;
  logic load_bubble;
  logic advance;
  logic is_ebreak;

  assign pc_plus4    = pc + 32'd4;
  assign is_ebreak   = (i_inst == EBREAK_INST);
  assign o_addr_inst = pc;
  assign o_halted    = (state == ST_HALT);

  // Decode what this edge does; redirect beats stall, which beats a fetch.
  always_comb begin
    take_redirect = 1'b0;
    accept        = 1'b0;
    load_bubble   = 1'b0;
    advance       = 1'b0;
    next_state    = state;
    case (state)
      ST_BOOT: begin
        load_bubble = 1'b1;
        next_state  = ST_RUN;
      end
      ST_RUN: begin
        if (i_redirect) begin
          take_redirect = 1'b1;
          load_bubble   = 1'b1;
        end else if (i_stall) begin
          load_bubble = i_flush;
        end else if (i_flush) begin
          load_bubble = 1'b1;
          advance     = 1'b1;
        end else begin
          accept  = 1'b1;
          advance = !is_ebreak;
          if (is_ebreak) next_state = ST_HALT;
        end
      end
      ST_HALT: begin
        if (i_redirect) begin
          take_redirect = 1'b1;
          load_bubble   = 1'b1;
          next_state    = ST_RUN;
        end else if (i_stall) begin
          load_bubble = i_flush;
        end else begin
          load_bubble = 1'b1;
        end
      end
      default: begin
        load_bubble = 1'b1;
        next_state  = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_BOOT;
      pc            <= RESET_PC;
      pending       <= 1'b0;
      o_if_pc       <= 32'd0;
      o_if_pc4      <= 32'd0;
      o_if_inst     <= NOP_INST;
      o_if_valid    <= 1'b0;
      o_if_misalign <= 1'b0;
      o_fetch_cnt   <= 32'd0;
    end else begin
      state <= next_state;
      if (take_redirect) begin
        pc      <= {i_redirect_pc[31:2], 2'b00};
        pending <= (i_redirect_pc[1:0] != 2'b00);
      end else if (advance) begin
        pc <= pc_plus4;
      end
      // A bubble keeps the old pc/pc4 so downstream debug still sees the last address.
      if (accept) begin
        o_if_pc       <= pc;
        o_if_pc4      <= pc_plus4;
        o_if_inst     <= i_inst;
        o_if_valid    <= 1'b1;
        o_if_misalign <= pending;
        pending       <= 1'b0;
        o_fetch_cnt   <= o_fetch_cnt + 32'd1;
      end else if (load_bubble) begin
        o_if_inst     <= NOP_INST;
        o_if_valid    <= 1'b0;
        o_if_misalign <= 1'b0;
      end
    end
  end

endmodule
